// File: rtl/rot_shift_sequencer_if.sv
// Request/response bundle for rot_shift_sequencer: start/op/operand/amount in,
// busy/done/result out.
interface rot_shift_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, operand, amount,
        input  busy, done, result
    );

    modport slave (
        input  start, op, operand, amount,
        output busy, done, result
    );
endinterface

// File: rtl/rot_shift_sequencer.sv
// Multi-cycle rotate/shift sequencer stepping a narrow datapath once per cycle.
// Optional macro ROT_SHIFT_FAST_STEP_EN adds a 4-bit step while cnt >= 4.
module rot_shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    rot_shift_sequencer_if.slave bus
);
    localparam logic [2:0] OP_ROL  = 3'b000;
    localparam logic [2:0] OP_ROR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SHRA = 3'b100;

    localparam logic [AMT_W-1:0] CNT_ZERO = '0;
    localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] result_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic [2:0]       opr_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] step1_next;
    logic [WIDTH-1:0] work_next;
    logic [AMT_W-1:0] cnt_next;
    logic             start_passthru;

    genvar gi;

    // One-bit step, built per output bit. Shift sources coincide with the
    // rotate sources except at the vacated end, where fill bits are forced.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step1
            localparam int ROL_SRC = (gi + WIDTH - 1) % WIDTH;
            localparam int ROR_SRC = (gi + 1) % WIDTH;
            localparam bit AT_LSB  = (gi == 0);
            localparam bit AT_MSB  = (gi == WIDTH - 1);
            logic bit_next;
            always_comb begin
                bit_next = work_reg[gi];
                case (opr_reg)
                    OP_ROL:  bit_next = work_reg[ROL_SRC];
                    OP_ROR:  bit_next = work_reg[ROR_SRC];
                    OP_SHL:  bit_next = AT_LSB ? 1'b0 : work_reg[ROL_SRC];
                    OP_SHR:  bit_next = AT_MSB ? 1'b0 : work_reg[ROR_SRC];
                    OP_SHRA: bit_next = AT_MSB ? work_reg[WIDTH-1] : work_reg[ROR_SRC];
                    default: ;
                endcase
            end
            assign step1_next[gi] = bit_next;
        end
    endgenerate

`ifdef ROT_SHIFT_FAST_STEP_EN
    localparam logic [AMT_W-1:0] CNT_FOUR = AMT_W'(4);

    logic [WIDTH-1:0] step4_next;
    logic             use_wide;

    // Four-bit step with the same op; the low/high four bits take the fill.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step4
            localparam int ROL_SRC = (gi + WIDTH - 4) % WIDTH;
            localparam int ROR_SRC = (gi + 4) % WIDTH;
            localparam bit LO_FILL = (gi < 4);
            localparam bit HI_FILL = (gi + 4 >= WIDTH);
            logic bit_next;
            always_comb begin
                bit_next = work_reg[gi];
                case (opr_reg)
                    OP_ROL:  bit_next = work_reg[ROL_SRC];
                    OP_ROR:  bit_next = work_reg[ROR_SRC];
                    OP_SHL:  bit_next = LO_FILL ? 1'b0 : work_reg[ROL_SRC];
                    OP_SHR:  bit_next = HI_FILL ? 1'b0 : work_reg[ROR_SRC];
                    OP_SHRA: bit_next = HI_FILL ? work_reg[WIDTH-1] : work_reg[ROR_SRC];
                    default: ;
                endcase
            end
            assign step4_next[gi] = bit_next;
        end
    endgenerate

    assign use_wide  = (cnt_reg >= CNT_FOUR);
    assign work_next = use_wide ? step4_next : step1_next;
    assign cnt_next  = cnt_reg - (use_wide ? CNT_FOUR : CNT_ONE);
`else
    assign work_next = step1_next;
    assign cnt_next  = cnt_reg - CNT_ONE;
`endif

    // Zero amount or a reserved op skips RUN and passes the operand through.
    assign start_passthru = (bus.amount == CNT_ZERO) || (bus.op > OP_SHRA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            work_reg   <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            opr_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        work_reg  <= bus.operand;
                        cnt_reg   <= bus.amount;
                        opr_reg   <= bus.op;
                        busy_reg  <= 1'b1;
                        state_reg <= start_passthru ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    work_reg <= work_next;
                    cnt_reg  <= cnt_next;
                    if (cnt_next == CNT_ZERO) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    // done and result land together as the unit returns to IDLE,
                    // so a start seen alongside done is accepted immediately.
                    done_reg   <= 1'b1;
                    result_reg <= work_reg;
                    busy_reg   <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_rot_shift_sequencer.sv
// Scoreboard bench for rot_shift_sequencer: driver pushes expected results and
// timing, a negedge monitor pops and checks on every done pulse.
module tb_rot_shift_sequencer;
    localparam int WIDTH = 32;
    localparam int AMT_W = 5;

    localparam logic [2:0] ROL  = 3'd0;
    localparam logic [2:0] ROR  = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] SHR  = 3'd3;
    localparam logic [2:0] SHRA = 3'd4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rot_shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    rot_shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          exp_cyc;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   free_cyc = 0;
    bit   mon_hold = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] x, input int a);
        if (a == 0) return x;
        case (op)
            ROL:     return (x << a) | (x >> (32 - a));
            ROR:     return (x >> a) | (x << (32 - a));
            SHL:     return x << a;
            SHR:     return x >> a;
            SHRA:    return 32'($signed(x) >>> a);
            default: return x;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input int a);
        if (op > SHRA) return 0;
`ifdef ROT_SHIFT_FAST_STEP_EN
        return a / 4 + a % 4;
`else
        return a;
`endif
    endfunction

    // Called at a negedge; waits until the model says the unit is idle.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input int a, input string tag);
        exp_t e;
        while (cyc < free_cyc) @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.operand = x;
        bus.amount  = a[4:0];
        e.acc     = cyc + 1;
        e.exp_cyc = e.acc + 1 + lat_of(op, a);
        e.res     = ref_model(op, x, a);
        e.tag     = tag;
        q.push_back(e);
        free_cyc = e.exp_cyc;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.op      = 3'($urandom);
        bus.operand = $urandom;
        bus.amount  = 5'($urandom);
    endtask

    task automatic check_zero(input string name);
        tests += 3;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL %s busy got=%b want=0", name, bus.busy); end
        if (bus.done !== 1'b0) begin fails++; $display("FAIL %s done got=%b want=0", name, bus.done); end
        if (bus.result !== 32'h0) begin fails++; $display("FAIL %s result got=%08h want=00000000", name, bus.result); end
    endtask

    // Monitor: busy checked every cycle, result and timing on each done.
    always @(negedge clk) begin
        logic exp_busy;
        exp_t e;
        if (!mon_hold) begin
            while (q.size() > 0 && cyc > q[0].exp_cyc) begin
                tests++; fails++;
                $display("FAIL %s missing done got=none want=cycle %0d", q[0].tag, q[0].exp_cyc);
                void'(q.pop_front());
            end
            exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].exp_cyc);
            tests++;
            if (bus.busy !== exp_busy) begin
                fails++;
                $display("FAIL busy at cycle %0d got=%b want=%b", cyc, bus.busy, exp_busy);
            end
            if (bus.done === 1'b1) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected done at cycle %0d got=1 want=0", cyc);
                end else begin
                    e = q.pop_front();
                    tests += 2;
                    if (bus.result !== e.res) begin
                        fails++;
                        $display("FAIL %s result got=%08h want=%08h", e.tag, bus.result, e.res);
                    end
                    if (cyc != e.exp_cyc) begin
                        fails++;
                        $display("FAIL %s done cycle got=%0d want=%0d", e.tag, cyc, e.exp_cyc);
                    end
                    $display("[TB] %s result=%08h expected=%08h done_cycle=%0d", e.tag, bus.result, e.res, cyc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.op      = 3'd0;
        bus.operand = 32'h0;
        bus.amount  = 5'd0;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset    = 1'b0;
        mon_hold = 1'b0;
        free_cyc = cyc;
        @(negedge clk);

        issue(ROL,  32'h8000_0001, 1,  "rol1");
        issue(ROR,  32'h1234_5678, 4,  "ror4");
        issue(SHRA, 32'h8000_0000, 31, "shra31");
        issue(SHR,  32'h8000_0000, 31, "shr31");
        issue(SHL,  32'h0000_0001, 31, "shl31");
        issue(ROL,  32'hDEAD_BEEF, 0,  "rol0");
        issue(3'd7, 32'hDEAD_BEEF, 7,  "reserved7");

        // Second start while busy must be ignored; next start lands back-to-back.
        issue(ROL, 32'h0F0F_00FF, 10, "rol10_first");
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = SHL;
        bus.operand = 32'hFFFF_0000;
        bus.amount  = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        issue(SHR, 32'hF000_000F, 5, "shr5_b2b");

        // Abort mid-operation with reset.
        issue(SHL, 32'h1234_5678, 20, "shl20_abort");
        repeat (4) @(negedge clk);
        mon_hold = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        check_zero("reset_abort");
        free_cyc = cyc;
        mon_hold = 1'b0;
        issue(SHRA, 32'h9000_0001, 3, "shra3_after_reset");

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rop;
            logic [31:0] rx;
            int          ra;
            rop = 3'($urandom_range(7, 0));
            rx  = $urandom;
            ra  = $urandom_range(31, 0);
            issue(rop, rx, ra, $sformatf("rand%0d_op%0d_a%0d", i, rop, ra));
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        while (cyc < free_cyc + 2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL pending transactions got=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
